block_serial_add_sub: RTL

- Multi-cycle adder/subtractor that resolves one BLOCK_SIZE-bit slice per clock, lowest slice first.
- Inside each slice, carries come from generate/propagate lookahead. A registered carry links one slice to the next.
- Trades latency for area against the fully combinational lookahead adder. Operands enter and results leave through valid/ready handshakes, so it sits between the operand source and the flag/result consumer in the datapath.

---
 rtl/block_serial_add_sub.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/block_serial_add_sub.sv
// block_serial_add_sub: multi-cycle adder/subtractor.
// Each clock resolves one BLOCK_SIZE-bit slice, starting with the lowest slice.
// Inside a slice, carries come from generate/propagate lookahead.
// A registered carry connects each slice to the next one.
// Operands enter through a valid/ready handshake, and results leave through another.
// Optional feature macro: ZERO_FLAG_EN adds the registered zero flag output ZF.
module block_serial_add_sub #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 2,
  localparam int STAGES_COUNT = DATA_WIDTH / BLOCK_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  sub,
  input  logic                  Cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] S,
  output logic                  CF,
`ifdef ZERO_FLAG_EN
  output logic                  ZF,
`endif
  output logic                  OF
);

  localparam int STAGE_W = (STAGES_COUNT > 1) ? $clog2(STAGES_COUNT) : 1;
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(STAGES_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;      // already inverted for subtraction
  logic                  sub_q;
  logic                  carry_q;  // carry into the current slice
  logic [STAGE_W-1:0]    stage_q;
  logic [DATA_WIDTH-1:0] s_q;
  logic [DATA_WIDTH-1:0] s_d;
  logic                  cf_q;
  logic                  of_q;
  logic                  in_ready_q;
  logic                  out_valid_q;

  // Datapath for the slice that stage_q currently selects.
  logic [BLOCK_SIZE-1:0] a_slice;
  logic [BLOCK_SIZE-1:0] b_slice;
  logic [BLOCK_SIZE-1:0] p;
  logic [BLOCK_SIZE-1:0] g;
  logic [BLOCK_SIZE-1:0] sum_slice;
  logic [BLOCK_SIZE:0]   c;

`ifdef ZERO_FLAG_EN
  logic zf_acc_q;  // running AND of the per-slice zero checks
  logic zf_q;
  logic slice_zero;
`endif

  // Expanded lookahead carry into bit idx+1 of the slice. Each term is a generate
  // that propagates through all higher bits up to idx. The final term carries cin
  // through the whole chain.
  function automatic logic lookahead_carry(input logic [BLOCK_SIZE-1:0] gv,
                                           input logic [BLOCK_SIZE-1:0] pv,
                                           input logic                  cin,
                                           input int                    idx);
    logic acc;
    logic prop;
    acc  = gv[idx];
    prop = pv[idx];
    for (int j = idx - 1; j >= 0; j--) begin
      acc  = acc | (prop & gv[j]);
      prop = prop & pv[j];
    end
    return acc | (prop & cin);
  endfunction

  // Select the operand slice. Constant-index decode keeps the mux simple.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int k = 0; k < STAGES_COUNT; k++) begin
      if (stage_q == STAGE_W'(k)) begin
        a_slice = a_q[k*BLOCK_SIZE +: BLOCK_SIZE];
        b_slice = b_q[k*BLOCK_SIZE +: BLOCK_SIZE];
      end
    end
  end

  assign c[0] = carry_q;

  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_SIZE; gi++) begin : g_bit
      assign p[gi]         = a_slice[gi] ^ b_slice[gi];
      assign g[gi]         = a_slice[gi] & b_slice[gi];
      assign c[gi+1]       = lookahead_carry(g, p, carry_q, gi);
      assign sum_slice[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  // Merge the freshly computed slice into its position in the result word.
  always_comb begin
    s_d = s_q;
    for (int k = 0; k < STAGES_COUNT; k++) begin
      if (stage_q == STAGE_W'(k)) begin
        s_d[k*BLOCK_SIZE +: BLOCK_SIZE] = sum_slice;
      end
    end
  end

`ifdef ZERO_FLAG_EN
  assign slice_zero = (sum_slice == '0);
`endif

  // Control FSM. All outputs and datapath state are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      stage_q     <= '0;
      s_q         <= '0;
      cf_q        <= 1'b0;
      of_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ZERO_FLAG_EN
      zf_acc_q    <= 1'b0;
      zf_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= A;
            b_q        <= sub ? ~B : B;
            sub_q      <= sub;
            carry_q    <= sub ? ~Cin : Cin;
            stage_q    <= '0;
            in_ready_q <= 1'b0;
`ifdef ZERO_FLAG_EN
            zf_acc_q   <= 1'b1;
`endif
            state_q    <= RUN;
          end
        end
        RUN: begin
          s_q     <= s_d;
          carry_q <= c[BLOCK_SIZE];
`ifdef ZERO_FLAG_EN
          zf_acc_q <= zf_acc_q & slice_zero;
`endif
          if (stage_q == LAST_STAGE) begin
            // Carry out of the MSB and carry into the MSB drive the flags.
            cf_q        <= sub_q ? ~c[BLOCK_SIZE] : c[BLOCK_SIZE];
            of_q        <= c[BLOCK_SIZE] ^ c[BLOCK_SIZE-1];
`ifdef ZERO_FLAG_EN
            zf_q        <= zf_acc_q & slice_zero;
`endif
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            stage_q <= stage_q + STAGE_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign CF        = cf_q;
  assign OF        = of_q;
`ifdef ZERO_FLAG_EN
  assign ZF        = zf_q;
`endif

endmodule
